h_step_rk_unit: RTL
===================

# h_step_rk_unit

Parametrised, sequential successor to the RK4 step-size calculator: computes the integration step H = (C − X0) / N in signed fixed point, either by multiplying by a precomputed reciprocal or by true restoring division. It sits between the RK4 control FSM and the k1..k4 datapath. It runs once per `start` and returns H with a `done` pulse plus status flags.

## Interface
Parameters:
- `W`, 32: word width of all data ports, two's complement.
- `F`, 16: fraction bits (Q(W−F).F).

Ports:
- `clk`, input, 1: rising-edge clock.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `start`, input, 1: request; sampled only in IDLE.
- `mode`, input, 1: 0 = `n` holds 1/N (multiply); 1 = `n` holds N (divide).
- `x0`, input, W: initial abscissa X0.
- `c`, input, W: end point C.
- `n`, input, W: step count or its reciprocal, signed.
- `busy`, output, 1: operation in progress.
- `done`, output, 1: one-cycle pulse when results update.
- `h`, output, W: step size, two's complement, held until the next `done`.
- `h_sign`, output, 1: sign of the true result (before saturation and truncation).
- `overflow`, output, 1: result saturated.
- `div_zero`, output, 1: mode 1 with `n` = 0.

## Operation
- States: IDLE, SUB, MUL, DIV, FIX.
- IDLE:
  - `start`=1 captures `c`, `x0`, `n`, `mode` and moves to SUB.
  - `start` in any other state is ignored, not queued.
- SUB:
  - diff = c − x0 at W+1 bits, so it cannot wrap.
  - sd = sign(diff) XOR sign(n).
  - mag = |diff| and nm = |n|, unsigned.
  - Next state: mode 0 → MUL; mode 1 with nm=0 → FIX with div_zero; otherwise → DIV with iteration counter = D = W+1+F.
- MUL: single cycle. p = mag·nm (2W+1 bits); q = p >> F, truncated toward zero. Next state FIX.
- DIV:
  - Restoring division of (mag << F) by nm, one quotient bit per cycle, MSB first.
  - After D cycles, q = quotient, truncated toward zero.
  - Next state FIX.
- FIX:
  - If q > 2^(W−1)−1, q is clamped to 2^(W−1)−1 and overflow=1. Saturation is symmetric, so the result is never −2^(W−1).
  - h = sd ? −q : q.
  - h_sign = sd when diff≠0, else 0.
  - div_zero case: h = diff=0 ? 0 : (sign(diff) ? −(2^(W−1)−1) : 2^(W−1)−1); overflow=1, div_zero=1.
  - FIX registers h, h_sign, overflow, div_zero, pulses `done` and returns to IDLE.
- Reset (asynchronous, any time):
  - state goes to IDLE; busy, done, h, h_sign, overflow, div_zero all go to 0.
  - An operation in flight is aborted with no `done`.

## Timing
- Edge E0 samples `start`=1. `busy`=1 from after E0 until the edge where `done` rises; `busy`=0 during the `done` cycle.
- Latency from E0 to the edge that raises `done`:
  - mode 0: 3 edges.
  - mode 1: D+2 edges (49+2 = 51 at defaults).
  - div_zero: 2 edges.
- Back-to-back operation: `start` held high during the `done` cycle is accepted. The next result follows with no gap beyond the latency.
- Status outputs change only on the edge that raises `done`.

## Test plan
- Mode 0, W=32 F=16, c=0x000A0000 (10.0), x0=0, n=0x00004000 (0.25) → h=0x00028000, h_sign=0, overflow=0, `done` 3 edges after start, busy high for exactly those cycles.
- Mode 1, same c and x0, n=0x00040000 (4.0) → h=0x00028000, `done` at 51 edges. Then c=0, x0=0x00010000, n=0x00030000 → h=0xFFFFAAAB (−0x5555, truncated toward zero), h_sign=1.
- Saturation, mode 1: c=0x7FFF0000, x0=0x80000000, n=1 → h=0x7FFFFFFF, overflow=1. Same operands with c and x0 swapped → h=0x80000001, h_sign=1, overflow=1.
- Divide by zero, mode 1: n=0 with diff>0 → h=0x7FFFFFFF, div_zero=1, overflow=1, `done` at 2 edges. With diff=0 → h=0, h_sign=0.
- Start during busy is ignored: a second `start` with different operands mid-DIV does not change the result. Back-to-back: `start` held during `done` produces a second correct result.
- Reset mid-DIV: assert `rst_n`=0 at iteration 20 → all outputs 0 immediately, no `done`. A new start after release completes normally.

Source files
------------

// File: rtl/h_step_rk_unit.sv
// RK4 step-size unit: H = (C - X0) / N in signed Q(W-F).F fixed point.
// The result comes either from a multiply by a precomputed 1/N or from a restoring divide by N.
module h_step_rk_unit #(
    parameter int W = 32,
    parameter int F = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         mode,
    input  logic [W-1:0] x0,
    input  logic [W-1:0] c,
    input  logic [W-1:0] n,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] h,
    output logic         h_sign,
    output logic         overflow,
    output logic         div_zero
);

    localparam int D  = W + 1 + F;
    localparam int PW = 2 * W + 1;
    localparam int CW = $clog2(D + 1);
    localparam logic [W-1:0] MAX_POS = {1'b0, {(W-1){1'b1}}};

    typedef enum logic [2:0] {IDLE, SUB, MUL, DIV, FIX} state_t;

    state_t         state, state_next;
    logic           mode_r;
    logic [W-1:0]   c_r, x0_r, n_r;
    logic           diff_neg_r, diff_zero_r, sd_r, dz_r;
    logic [W:0]     mag_r;
    logic [W-1:0]   nm_r;
    logic [PW-1:0]  q_r;
    logic [W-1:0]   rem_r;
    logic [CW-1:0]  cnt_r;

    logic [W:0]     diff_c;
    logic [W:0]     mag_c;
    logic [W-1:0]   nm_c;
    logic [W:0]     trial;
    logic           ge;
    logic [PW-1:0]  prod;
    logic           sat;
    logic [W-1:0]   qc;

    // Difference is taken one bit wider than the operands so it can never wrap.
    assign diff_c = {c_r[W-1], c_r} - {x0_r[W-1], x0_r};
    assign mag_c  = diff_c[W] ? -diff_c : diff_c;
    assign nm_c   = n_r[W-1] ? -n_r : n_r;

    // Remainder stays below nm <= 2^(W-1), so W bits hold it and the trial needs W+1.
    assign trial = {rem_r, q_r[D-1]};
    assign ge    = (trial >= {1'b0, nm_r});

    assign prod = {{W{1'b0}}, mag_r} * {{(W+1){1'b0}}, nm_r};

    assign sat = (q_r > {{(PW-W){1'b0}}, MAX_POS});
    assign qc  = sat ? MAX_POS : q_r[W-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (start) state_next = SUB;
            SUB: begin
                if (!mode_r)            state_next = MUL;
                else if (nm_c == '0)    state_next = FIX;
                else                    state_next = DIV;
            end
            MUL:  state_next = FIX;
            DIV:  if (cnt_r == CW'(1)) state_next = FIX;
            FIX:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // q_r doubles as the shifting dividend/quotient register during DIV.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_r      <= 1'b0;
            c_r         <= '0;
            x0_r        <= '0;
            n_r         <= '0;
            diff_neg_r  <= 1'b0;
            diff_zero_r <= 1'b0;
            sd_r        <= 1'b0;
            dz_r        <= 1'b0;
            mag_r       <= '0;
            nm_r        <= '0;
            q_r         <= '0;
            rem_r       <= '0;
            cnt_r       <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            h           <= '0;
            h_sign      <= 1'b0;
            overflow    <= 1'b0;
            div_zero    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        mode_r <= mode;
                        c_r    <= c;
                        x0_r   <= x0;
                        n_r    <= n;
                        busy   <= 1'b1;
                    end
                end
                SUB: begin
                    diff_neg_r  <= diff_c[W];
                    diff_zero_r <= (diff_c == '0);
                    sd_r        <= diff_c[W] ^ n_r[W-1];
                    dz_r        <= mode_r && (nm_c == '0);
                    mag_r       <= mag_c;
                    nm_r        <= nm_c;
                    q_r         <= '0;
                    q_r[D-1:0]  <= {mag_c, {F{1'b0}}};
                    rem_r       <= '0;
                    cnt_r       <= CW'(D);
                end
                MUL: begin
                    q_r <= prod >> F;
                end
                DIV: begin
                    rem_r      <= ge ? (trial[W-1:0] - nm_r) : trial[W-1:0];
                    q_r[D-1:0] <= {q_r[D-2:0], ge};
                    cnt_r      <= cnt_r - CW'(1);
                end
                FIX: begin
                    busy   <= 1'b0;
                    done   <= 1'b1;
                    h_sign <= sd_r & ~diff_zero_r;
                    if (dz_r) begin
                        h        <= diff_zero_r ? '0 : (diff_neg_r ? -MAX_POS : MAX_POS);
                        overflow <= 1'b1;
                        div_zero <= 1'b1;
                    end else begin
                        h        <= sd_r ? -qc : qc;
                        overflow <= sat;
                        div_zero <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
